// File: rtl/delay_sched_pkg.sv
// rtl/delay_sched_pkg.sv - shared state encoding and board tick constants for delay_sched
package delay_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } sched_state_t;

    // Prescaler lengths for the 50 MHz board clock
    localparam int TICK_100MS = 5000000;
    localparam int TICK_20MS  = 1000000;
    localparam int TICK_2MS   = 100000;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/delay_sched_if.sv
// rtl/delay_sched_if.sv - requester-side bundle of the shared delay scheduler
interface delay_sched_if #(
    parameter int N_REQ = 3,
    parameter int DLY_W = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*DLY_W-1:0] dly;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic                   busy;

    modport master (output req, output dly, input gnt, input done, input busy);
    modport slave  (input req, input dly, output gnt, output done, output busy);
endinterface

// File: rtl/delay_sched_rr_pick.sv
// rtl/delay_sched_rr_pick.sv - combinational round-robin first-set search from a pointer
module delay_sched_rr_pick
    import delay_sched_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/delay_sched.sv
// rtl/delay_sched.sv - shared prescaler/countdown granted round-robin to delay requesters
module delay_sched
    import delay_sched_pkg::*;
#(
    parameter int TICK_CYCLES = TICK_100MS,
    parameter int N_REQ       = 3,
    parameter int DLY_W       = 8
) (
    input  logic         clkin,
    input  logic         rst,
    delay_sched_if.slave bus
);

    localparam int PS_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int IDX_W = idx_width(N_REQ);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    sched_state_t     state;
    logic [PS_W-1:0]  presc;
    logic [DLY_W-1:0] remaining;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] done_q;
    logic             busy_q;

    logic [N_REQ-1:0] win_oh;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;
    logic             tick;

    delay_sched_rr_pick #(.N(N_REQ), .IW(IDX_W)) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .onehot (win_oh),
        .idx    (win_idx),
        .any    (win_any)
    );

    assign tick     = (presc == PS_LAST);
    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;

    always_ff @(posedge clkin) begin
        if (rst) begin
            state     <= ST_IDLE;
            presc     <= '0;
            remaining <= '0;
            ptr       <= '0;
            owner     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        gnt_q     <= win_oh;
                        busy_q    <= 1'b1;
                        owner     <= win_idx;
                        remaining <= bus.dly[int'(win_idx)*DLY_W +: DLY_W];
                        presc     <= '0;
                        ptr       <= (win_idx == IDX_LAST) ? '0 : win_idx + IDX_W'(1);
                        state     <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (!bus.req[owner]) begin
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (remaining == '0) begin
                        // zero delay: this single cycle puts done one cycle after gnt
                        done_q <= gnt_q;
                        state  <= ST_DONE;
                    end else begin
                        presc <= tick ? '0 : presc + PS_W'(1);
                        if (tick) begin
                            remaining <= remaining - DLY_W'(1);
                            if (remaining == DLY_W'(1)) begin
                                done_q <= gnt_q;
                                state  <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    gnt_q  <= '0;
                    done_q <= '0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_sched.sv
// tb/tb_delay_sched.sv - directed and randomized bench against a deadline-based scheduler model
module tb_delay_sched;

    localparam int T = 4;
    localparam int N = 3;
    localparam int W = 8;

    logic clkin = 1'b0;
    logic rst;

    always #5 clkin = ~clkin;

    delay_sched_if #(.N_REQ(N), .DLY_W(W)) bus_if ();

    delay_sched #(.TICK_CYCLES(T), .N_REQ(N), .DLY_W(W)) dut (
        .clkin (clkin),
        .rst   (rst),
        .bus   (bus_if)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // model: who owns the timer, when it was granted, and how long it lasts
    int         m_phase = 0;  // 0 idle, 1 owned, 2 completion cycle
    int         m_owner = 0;
    int         m_ptr   = 0;
    int         m_grant_edge = 0;
    int         m_len   = 0;
    int         edge_n  = 0;
    logic [N-1:0] m_gnt  = '0;
    logic [N-1:0] m_done = '0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t got=%0d exp=%0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge();
        int w;
        int d;
        edge_n++;
        if (rst) begin
            m_phase = 0;
            m_ptr   = 0;
            m_gnt   = '0;
            m_done  = '0;
        end else if (m_phase == 0) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && bus_if.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0) begin
                d            = int'(bus_if.dly[w*W +: W]);
                m_owner      = w;
                m_len        = (d == 0) ? 1 : d * T;
                m_grant_edge = edge_n;
                m_ptr        = (w + 1) % N;
                m_gnt        = '0;
                m_gnt[w]     = 1'b1;
                m_phase      = 1;
            end
        end else if (m_phase == 1) begin
            if (!bus_if.req[m_owner]) begin
                m_gnt   = '0;
                m_phase = 0;
            end else if (edge_n - m_grant_edge == m_len) begin
                m_done  = m_gnt;
                m_phase = 2;
            end
        end else begin
            m_gnt   = '0;
            m_done  = '0;
            m_phase = 0;
        end
    endtask

    task automatic cycle_chk();
        @(posedge clkin);
        model_edge();
        @(negedge clkin);
        check_val("gnt",  int'(bus_if.gnt),  int'(m_gnt));
        check_val("done", int'(bus_if.done), int'(m_done));
        check_val("busy", int'(bus_if.busy), int'(m_gnt != '0));
        check_val("gnt_onehot0", int'($onehot0(bus_if.gnt)), 1);
        check_val("done_in_gnt", int'(bus_if.done & ~bus_if.gnt), 0);
    endtask

    task automatic set_dly(input int i, input int v);
        bus_if.dly[i*W +: W] = W'(v);
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        bus_if.req = '0;
        cycle_chk();
        cycle_chk();
        rst = 1'b0;
    endtask

    // g: cycle index of first grant seen, lat: cycles from that grant to done (-1 on timeout)
    task automatic run_until_done(input int max, output int g, output int lat, output int dval);
        g    = -1;
        lat  = -1;
        dval = 0;
        for (int c = 0; c < max; c++) begin
            cycle_chk();
            if (g < 0 && bus_if.gnt != '0) g = c;
            if (bus_if.done != '0) begin
                lat  = c - g;
                dval = int'(bus_if.done);
                break;
            end
        end
        if (lat < 0) check_val("done_timeout", lat, 0);
    endtask

    initial begin
        int g, lat, dv;
        rst        = 1'b1;
        bus_if.req = 3'b111;
        bus_if.dly = '0;
        for (int i = 0; i < N; i++) set_dly(i, 1);

        // 1: grants held off during reset, req[0] wins right after release
        cycle_chk();
        cycle_chk();
        rst = 1'b0;
        cycle_chk();
        check_val("t1_first_gnt", int'(bus_if.gnt), 1);

        // 2: single requester, 3 ticks
        apply_reset();
        set_dly(1, 3);
        bus_if.req = 3'b010;
        run_until_done(60, g, lat, dv);
        check_val("t2_gnt_delay", g, 0);
        check_val("t2_latency", lat, 3 * T);
        check_val("t2_done", dv, 2);
        bus_if.req = '0;
        cycle_chk();
        check_val("t2_gnt_clear", int'(bus_if.gnt), 0);

        // 3: all requesting, round-robin 0,1,2,0 with one idle cycle between
        apply_reset();
        for (int i = 0; i < N; i++) set_dly(i, 1);
        bus_if.req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            run_until_done(30, g, lat, dv);
            check_val("t3_order", dv, 1 << (k % N));
            check_val("t3_latency", lat, T);
            check_val("t3_gap", g, (k == 0) ? 0 : 1);
        end

        // 4: zero delay finishes the cycle after grant
        apply_reset();
        bus_if.req = '0;
        set_dly(2, 0);
        bus_if.req = 3'b100;
        run_until_done(10, g, lat, dv);
        check_val("t4_latency", lat, 1);
        check_val("t4_done", dv, 4);
        bus_if.req = '0;
        cycle_chk();
        check_val("t4_busy_after", int'(bus_if.busy), 0);

        // 5: owner drops mid-count, waiting requester takes over after one idle cycle
        apply_reset();
        set_dly(0, 5);
        set_dly(1, 2);
        bus_if.req = 3'b001;
        cycle_chk();
        check_val("t5_gnt0", int'(bus_if.gnt), 1);
        for (int c = 0; c < 6; c++) cycle_chk();
        bus_if.req = 3'b010;
        cycle_chk();
        check_val("t5_abort_gnt", int'(bus_if.gnt), 0);
        check_val("t5_abort_done", int'(bus_if.done), 0);
        cycle_chk();
        check_val("t5_next_gnt", int'(bus_if.gnt), 2);
        run_until_done(30, g, lat, dv);
        check_val("t5_done1", dv, 2);
        bus_if.req = '0;
        cycle_chk();

        // 6: reset mid-count drops the grant silently and restores priority to req[0]
        apply_reset();
        set_dly(2, 4);
        bus_if.req = 3'b100;
        for (int c = 0; c < 6; c++) cycle_chk();
        check_val("t6_counting", int'(bus_if.gnt), 4);
        rst = 1'b1;
        cycle_chk();
        check_val("t6_rst_gnt", int'(bus_if.gnt), 0);
        check_val("t6_rst_done", int'(bus_if.done), 0);
        rst        = 1'b0;
        bus_if.req = 3'b101;
        cycle_chk();
        check_val("t6_ptr_reset", int'(bus_if.gnt), 1);

        // random traffic: toggling requests, occasional owner aborts, rare resets
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (bus_if.gnt[i]) begin
                    if ($urandom_range(0, 39) == 0) bus_if.req[i] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    bus_if.req[i] = ~bus_if.req[i];
                end
                if ($urandom_range(0, 3) == 0) set_dly(i, $urandom_range(0, 5));
            end
            cycle_chk();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
